// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-Avalon-MM bridge.
//   - command codes and the error byte returned for an unknown command
//   - bridge FSM state encoding
//   - status byte bit positions and a helper that builds the status byte
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // Status byte layout: {5'b0, bus_timeout, response[1:0]}
    localparam int unsigned STAT_RESP_LSB = 0;
    localparam int unsigned STAT_BUS_TMO  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRxAddr,
        StRxData,
        StBusWr,
        StBusRd,
        StTxStatus,
        StTxWait,
        StTxData
    } state_e;

    function automatic logic [7:0] status_byte(input logic bus_tmo, input logic [1:0] resp);
        logic [7:0] s;
        s                        = '0;
        s[STAT_RESP_LSB +: 2]    = resp;
        s[STAT_BUS_TMO]          = bus_tmo;
        return s;
    endfunction

endpackage

// File: rtl/uart_bridge_resp_tx.sv
// Response serializer for the UART bridge.
// Loads a status byte plus 0 or 4 data bytes, then launches one byte per
// send request on data_tx / data_tx_wr (LSB first after the status byte).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture load_status / load_data / load_with_data
//   send              launch the next byte (pulses data_tx_wr next cycle)
//   data_tx_ack       previous byte transmitted
//   data_tx           byte to the UART transmitter (registered)
//   data_tx_wr        one-cycle launch pulse (registered)
//   more              bytes remain to be launched
//   done              last byte acknowledged this cycle
module uart_bridge_resp_tx import uart_bridge_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  load_status,
    input  logic [31:0] load_data,
    input  logic        load_with_data,
    input  logic        send,
    input  logic        data_tx_ack,
    output logic [7:0]  data_tx,
    output logic        data_tx_wr,
    output logic        more,
    output logic        done
);

    logic [39:0] buf_q, buf_d;
    logic [2:0]  left_q, left_d;
    logic [7:0]  data_q, data_d;
    logic        wr_q, wr_d;

    always_comb begin
        buf_d  = buf_q;
        left_d = left_q;
        data_d = data_q;
        wr_d   = 1'b0;
        if (load) begin
            buf_d  = {load_data, load_status};
            left_d = load_with_data ? 3'd5 : 3'd1;
        end else if (send) begin
            data_d = buf_q[7:0];
            wr_d   = 1'b1;
            buf_d  = {8'h00, buf_q[39:8]};
            left_d = left_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            left_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            left_q <= left_d;
            data_q <= data_d;
            wr_q   <= wr_d;
        end
    end

    assign data_tx    = data_q;
    assign data_tx_wr = wr_q;
    assign more       = (left_q != 3'd0);
    assign done       = data_tx_ack && (left_q == 3'd0);

endmodule

// File: rtl/uart_avl_mm_bridge.sv
// UART-to-Avalon-MM bridge master.
// Parses 0x57 ADDR D0..D3 (write) and 0x52 ADDR (read) frames from the UART
// receiver, issues one 32-bit Avalon-MM transfer, then returns a status byte
// (plus 4 read-data bytes, LSB first) through the UART transmitter. Any other
// command byte is answered with 0xEE.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   data_rx/_ready/_ack                UART receive byte handshake
//   data_tx/_wr/_ack                   UART transmit byte handshake
//   avl_mm_*                           Avalon-MM initiator port
//   busy                               FSM is not idle
// Optional: define UART_BRIDGE_BUS_TIMEOUT_EN to abort transfers whose
// waitrequest stays high for BUS_TIMEOUT clocks (status bit2 set).
module uart_avl_mm_bridge import uart_bridge_pkg::*; #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned RX_TIMEOUT  = 100000,
    parameter int unsigned BUS_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_rx,
    input  logic                  data_rx_ready,
    output logic                  data_rx_ack,
    output logic [7:0]            data_tx,
    output logic                  data_tx_wr,
    input  logic                  data_tx_ack,
    output logic [ADDR_WIDTH-1:0] avl_mm_addr,
    output logic                  avl_mm_read,
    input  logic [31:0]           avl_mm_readdata,
    input  logic [1:0]            avl_mm_response,
    output logic                  avl_mm_write,
    output logic [31:0]           avl_mm_writedata,
    output logic [3:0]            avl_mm_byteenable,
    input  logic                  avl_mm_waitrequest,
    output logic                  busy
);

    if (ADDR_WIDTH != 8) begin : g_addr_chk
        $error("uart_avl_mm_bridge: ADDR_WIDTH must be 8");
    end
    if (BUS_TIMEOUT == 0) begin : g_tmo_chk
        $error("uart_avl_mm_bridge: BUS_TIMEOUT must be non-zero");
    end

    localparam int unsigned    RxTmoW    = $clog2(RX_TIMEOUT + 1);
    localparam logic [RxTmoW-1:0] RxTmoLast = RxTmoW'(RX_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    is_rd_q, is_rd_d;
    logic [RxTmoW-1:0]       rx_tmo_q, rx_tmo_d;
    logic                    bus_expired;

    logic        load, load_with_data, tx_send, tx_more, tx_done;
    logic [7:0]  load_status;
    logic [31:0] load_data;

`ifdef UART_BRIDGE_BUS_TIMEOUT_EN
    localparam int unsigned        BusTmoW    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BusTmoW-1:0] BusTmoLast = BusTmoW'(BUS_TIMEOUT - 1);
    logic [BusTmoW-1:0] bus_tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_tmo_q <= '0;
        end else if ((state_q == StBusWr) || (state_q == StBusRd)) begin
            bus_tmo_q <= bus_tmo_q + 1'b1;
        end else begin
            bus_tmo_q <= '0;
        end
    end

    assign bus_expired = (bus_tmo_q == BusTmoLast);
`else
    assign bus_expired = 1'b0;
`endif

    assign data_rx_ack = data_rx_ready &&
                         ((state_q == StIdle) || (state_q == StRxAddr) || (state_q == StRxData));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        is_rd_d        = is_rd_q;
        rx_tmo_d       = '0;
        load           = 1'b0;
        load_status    = '0;
        load_data      = '0;
        load_with_data = 1'b0;
        tx_send        = 1'b0;

        if ((state_q == StRxAddr) || (state_q == StRxData)) begin
            rx_tmo_d = data_rx_ack ? '0 : rx_tmo_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (data_rx_ready) begin
                    if (data_rx == CMD_WR) begin
                        is_rd_d = 1'b0;
                        state_d = StRxAddr;
                    end else if (data_rx == CMD_RD) begin
                        is_rd_d = 1'b1;
                        state_d = StRxAddr;
                    end else begin
                        load        = 1'b1;
                        load_status = ERR_BYTE;
                        state_d     = StTxStatus;
                    end
                end
            end
            StRxAddr: begin
                // An arriving byte takes priority over the idle limit.
                if (data_rx_ready) begin
                    addr_d  = data_rx[ADDR_WIDTH-1:0];
                    state_d = is_rd_q ? StBusRd : StRxData;
                end else if (rx_tmo_q == RxTmoLast) begin
                    state_d = StIdle;
                end
            end
            StRxData: begin
                if (data_rx_ready) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = data_rx;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StBusWr;
                    end
                end else if (rx_tmo_q == RxTmoLast) begin
                    state_d = StIdle;
                end
            end
            StBusWr, StBusRd: begin
                if (!avl_mm_waitrequest) begin
                    load           = 1'b1;
                    load_status    = status_byte(1'b0, avl_mm_response);
                    load_data      = avl_mm_readdata;
                    load_with_data = (state_q == StBusRd);
                    state_d        = StTxStatus;
                end else if (bus_expired) begin
                    load           = 1'b1;
                    load_status    = status_byte(1'b1, 2'b00);
                    load_with_data = (state_q == StBusRd);
                    state_d        = StTxStatus;
                end
            end
            StTxStatus: begin
                tx_send = 1'b1;
                state_d = StTxWait;
            end
            StTxWait: begin
                if (tx_done) begin
                    state_d = StIdle;
                end else if (data_tx_ack && tx_more) begin
                    state_d = StTxData;
                end
            end
            StTxData: begin
                tx_send = 1'b1;
                state_d = StTxWait;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            is_rd_q  <= 1'b0;
            rx_tmo_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            is_rd_q  <= is_rd_d;
            rx_tmo_q <= rx_tmo_d;
        end
    end

    uart_bridge_resp_tx u_resp_tx (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .load_status    (load_status),
        .load_data      (load_data),
        .load_with_data (load_with_data),
        .send           (tx_send),
        .data_tx_ack    (data_tx_ack),
        .data_tx        (data_tx),
        .data_tx_wr     (data_tx_wr),
        .more           (tx_more),
        .done           (tx_done)
    );

    // Strobes decode straight from the state register so reset drops them at once.
    assign avl_mm_read       = (state_q == StBusRd);
    assign avl_mm_write      = (state_q == StBusWr);
    assign avl_mm_byteenable = (avl_mm_read || avl_mm_write) ? 4'hF : 4'h0;
    assign avl_mm_addr       = addr_q;
    assign avl_mm_writedata  = wdata_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_uart_avl_mm_bridge.sv
module tb_uart_avl_mm_bridge;

    localparam int unsigned RxTmo  = 200;
    localparam int unsigned BusTmo = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_rx = 8'h00;
    logic        data_rx_ready = 1'b0;
    logic        data_rx_ack;
    logic [7:0]  data_tx;
    logic        data_tx_wr;
    logic        data_tx_ack;
    logic [7:0]  avl_mm_addr;
    logic        avl_mm_read;
    logic [31:0] avl_mm_readdata;
    logic [1:0]  avl_mm_response = 2'b00;
    logic        avl_mm_write;
    logic [31:0] avl_mm_writedata;
    logic [3:0]  avl_mm_byteenable;
    logic        avl_mm_waitrequest;
    logic        busy;

    always #5 clk = ~clk;

    uart_avl_mm_bridge #(
        .ADDR_WIDTH  (8),
        .RX_TIMEOUT  (RxTmo),
        .BUS_TIMEOUT (BusTmo)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_rx            (data_rx),
        .data_rx_ready      (data_rx_ready),
        .data_rx_ack        (data_rx_ack),
        .data_tx            (data_tx),
        .data_tx_wr         (data_tx_wr),
        .data_tx_ack        (data_tx_ack),
        .avl_mm_addr        (avl_mm_addr),
        .avl_mm_read        (avl_mm_read),
        .avl_mm_readdata    (avl_mm_readdata),
        .avl_mm_response    (avl_mm_response),
        .avl_mm_write       (avl_mm_write),
        .avl_mm_writedata   (avl_mm_writedata),
        .avl_mm_byteenable  (avl_mm_byteenable),
        .avl_mm_waitrequest (avl_mm_waitrequest),
        .busy               (busy)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];

    int compared   = 0;
    int mismatched = 0;

    int          slave_ws    = 0;
    bit          slave_hang  = 0;
    logic [31:0] slave_rdata = 32'h0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART transmitter model + response scoreboard.
    initial begin : tx_mon
        int pend;
        pend = 0;
        data_tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            data_tx_ack = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) data_tx_ack = 1'b1;
            end
            if (data_tx_wr) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected", {32'h0, data_tx}, 40'hFF_FFFF_FFFF);
                end else begin
                    chk("tx_byte", {32'h0, data_tx}, {32'h0, tx_q.pop_front()});
                end
                pend = 3;
            end
        end
    end

    // Avalon slave model + bus scoreboard.
    initial begin : bus_mon
        int len;
        bit prev;
        bit strobe;
        bus_t e;
        len = 0;
        prev = 0;
        avl_mm_waitrequest = 1'b1;
        avl_mm_readdata = 32'h0;
        forever begin
            @(negedge clk);
            strobe = avl_mm_read | avl_mm_write;
            if (strobe) begin
                if (!prev) len = 0;
                len++;
                if (!slave_hang && len > slave_ws) begin
                    avl_mm_waitrequest = 1'b0;
                    avl_mm_readdata = avl_mm_read ? slave_rdata : 32'hDEAD_BEEF;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", {39'h0, avl_mm_write}, 40'hFF_FFFF_FFFF);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_kind", {39'h0, avl_mm_write}, {39'h0, e.is_wr});
                        chk("bus_addr", {32'h0, avl_mm_addr}, {32'h0, e.addr});
                        chk("bus_be", {36'h0, avl_mm_byteenable}, 40'hF);
                        chk("bus_len", 40'(len), 40'(e.len));
                        if (e.is_wr) chk("bus_wdata", {8'h0, avl_mm_writedata}, {8'h0, e.wdata});
                    end
                end else begin
                    avl_mm_waitrequest = 1'b1;
                end
            end else begin
                if (prev && slave_hang) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_abort_unexpected", 40'(len), 40'hFF_FFFF_FFFF);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_abort_len", 40'(len), 40'(e.len));
                    end
                end
                avl_mm_waitrequest = 1'b1;
            end
            prev = strobe;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        data_rx = b;
        data_rx_ready = 1'b1;
        #1;
        n = 0;
        while (!data_rx_ack && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!data_rx_ack) chk("rx_ack_timeout", 40'h0, 40'h1);
        @(posedge clk);
        #1;
        data_rx_ready = 1'b0;
    endtask

    task automatic push_bus(input bit is_wr, input logic [7:0] a, input logic [31:0] d,
                            input int len);
        bus_t e;
        e.is_wr = is_wr;
        e.addr  = a;
        e.wdata = d;
        e.len   = len;
        bus_q.push_back(e);
    endtask

    task automatic push_tx5(input logic [7:0] s, input logic [31:0] d);
        tx_q.push_back(s);
        tx_q.push_back(d[7:0]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[31:24]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, {38'h0, tx_q.size() != 0, bus_q.size() != 0}, 40'h0);
        chk({name, "_idle"}, {39'h0, busy}, 40'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_strobes", {36'h0, avl_mm_read, avl_mm_write, data_tx_wr, busy}, 40'h0);
        chk("rst_addr_be", {28'h0, avl_mm_addr, avl_mm_byteenable}, 40'h0);
        chk("rst_wdata_tx", {avl_mm_writedata, data_tx}, 40'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, zero wait states.
        slave_ws = 0;
        push_bus(1'b1, 8'h14, 32'h0000_1234, 1);
        tx_q.push_back(8'h00);
        send_byte(8'h57); send_byte(8'h14);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
        wait_drain("write");

        // Read, 3 wait states.
        slave_ws = 3;
        slave_rdata = 32'hA5A5_0003;
        push_bus(1'b0, 8'h08, 32'h0, 4);
        push_tx5(8'h00, 32'hA5A5_0003);
        send_byte(8'h52); send_byte(8'h08);
        wait_drain("read_ws3");

        // Unknown command, then a read with a non-OK response code.
        tx_q.push_back(8'hEE);
        send_byte(8'h33);
        wait_drain("bad_cmd");
        slave_ws = 0;
        slave_rdata = 32'h1122_3344;
        avl_mm_response = 2'b10;
        push_bus(1'b0, 8'h20, 32'h0, 1);
        push_tx5(8'h02, 32'h1122_3344);
        send_byte(8'h52); send_byte(8'h20);
        wait_drain("read_resp");
        avl_mm_response = 2'b00;

        // RX timeout drops a partial frame silently.
        send_byte(8'h57); send_byte(8'h10);
        repeat (RxTmo - 10) @(negedge clk);
        chk("rx_tmo_before", {39'h0, busy}, 40'h1);
        repeat (15) @(negedge clk);
        chk("rx_tmo_after", {39'h0, busy}, 40'h0);
        slave_rdata = 32'hCAFE_F00D;
        push_bus(1'b0, 8'h00, 32'h0, 1);
        push_tx5(8'h00, 32'hCAFE_F00D);
        send_byte(8'h52); send_byte(8'h00);
        wait_drain("after_rx_tmo");

`ifdef UART_BRIDGE_BUS_TIMEOUT_EN
        slave_hang = 1;
        push_bus(1'b0, 8'h30, 32'h0, BusTmo);
        push_tx5(8'h04, 32'h0);
        send_byte(8'h52); send_byte(8'h30);
        wait_drain("bus_tmo");
        slave_hang = 0;
`endif

        // Reset in the middle of a stalled write.
        slave_ws = 50;
        send_byte(8'h57); send_byte(8'h40);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        begin
            int n;
            n = 0;
            while (!avl_mm_write && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("mid_wr_strobe", {39'h0, avl_mm_write}, 40'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_write", {35'h0, avl_mm_write, avl_mm_byteenable}, 40'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", {39'h0, busy}, 40'h0);
        slave_ws = 0;
        slave_rdata = 32'h0BAD_0001;
        push_bus(1'b0, 8'h44, 32'h0, 1);
        push_tx5(8'h00, 32'h0BAD_0001);
        send_byte(8'h52); send_byte(8'h44);
        wait_drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
